// File: rtl/rf_wport_arbiter_if.sv
// Register-file write-port bundle: writeback request, long-latency result,
// registered register-file write, and the decode hazard query.
interface rf_wport_arbiter_if #(
  parameter int DEPTH = 2
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             wb_we;
  logic [6:0]       wb_addr;
  logic [31:0]      wb_data;
  logic             wb_stall;
  logic             lr_valid;
  logic [6:0]       lr_addr;
  logic [31:0]      lr_data;
  logic             lr_ready;
  logic             rf_we;
  logic [6:0]       rf_addr;
  logic [31:0]      rf_data;
  logic [6:0]       q_addr;
  logic             q_pending;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output wb_we, wb_addr, wb_data, lr_valid, lr_addr, lr_data, q_addr,
    input  wb_stall, lr_ready, rf_we, rf_addr, rf_data, q_pending, occupancy
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, lr_valid, lr_addr, lr_data, q_addr,
    output wb_stall, lr_ready, rf_we, rf_addr, rf_data, q_pending, occupancy
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the register-file write port between writeback (priority) and a
// buffered long-latency result source, with starvation relief and hazard query.
module rf_wport_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  rf_wport_arbiter_if.slave  bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int SC_W   = $clog2(STARVE_LIMIT + 1);
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    SEL_IDLE, SEL_STALL_DRAIN, SEL_WB, SEL_DRAIN, SEL_BYPASS
  } sel_e;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] buf_addr_q [DEPTH];
  logic [ADDR_W-1:0] buf_addr_d [DEPTH];
  logic [DATA_W-1:0] buf_data_q [DEPTH];
  logic [DATA_W-1:0] buf_data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic              wb_stall_q, wb_stall_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic empty, accept, drain, enq, hit;
  sel_e sel;

  always_comb begin
    empty  = (occ_q == '0);
    accept = bus.lr_valid && (occ_q < OCC_W'(DEPTH));
    sel    = SEL_IDLE;
    if (wb_stall_q && !empty)          sel = SEL_STALL_DRAIN;
    else if (bus.wb_we && !wb_stall_q) sel = SEL_WB;
    else if (!empty)                   sel = SEL_DRAIN;
    else if (accept)                   sel = SEL_BYPASS;
    drain = (sel == SEL_STALL_DRAIN) || (sel == SEL_DRAIN);
    enq   = accept && (sel != SEL_BYPASS);
  end

  always_comb begin
    valid_d    = valid_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    case (sel)
      SEL_STALL_DRAIN, SEL_DRAIN: begin
        // Killed entries still consume their slot, just without a write.
        rf_we_d         = valid_q[head_q] && (buf_addr_q[head_q] != '0);
        rf_addr_d       = buf_addr_q[head_q];
        rf_data_d       = buf_data_q[head_q];
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_W'(1);
      end
      SEL_WB: begin
        rf_we_d   = (bus.wb_addr != '0);
        rf_addr_d = bus.wb_addr;
        rf_data_d = bus.wb_data;
        for (int i = 0; i < DEPTH; i++) begin
          if (buf_addr_q[i] == bus.wb_addr) valid_d[i] = 1'b0;
        end
      end
      SEL_BYPASS: begin
        rf_we_d   = (bus.lr_addr != '0);
        rf_addr_d = bus.lr_addr;
        rf_data_d = bus.lr_data;
      end
      default: ;
    endcase
    // Enqueue after the kill so a same-cycle result to the same address stays live.
    if (enq) begin
      valid_d[tail_q]    = 1'b1;
      buf_addr_d[tail_q] = bus.lr_addr;
      buf_data_d[tail_q] = bus.lr_data;
      tail_d             = tail_q + PTR_W'(1);
    end
    occ_d = occ_q + OCC_W'(enq) - OCC_W'(drain);
  end

  always_comb begin
    sc_d = sc_q;
    if (empty || drain)    sc_d = '0;
    else if (sel == SEL_WB) sc_d = sc_q + SC_W'(1);
    wb_stall_d = (sc_d == SC_W'(STARVE_LIMIT));
  end

  always_comb begin
    hit = 1'b0;
    if (bus.q_addr != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (buf_addr_q[i] == bus.q_addr)) hit = 1'b1;
      end
      if (accept && (bus.lr_addr == bus.q_addr)) hit = 1'b1;
    end
  end

  // Registered state: control and write-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      sc_q       <= '0;
      wb_stall_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      sc_q       <= sc_d;
      wb_stall_q <= wb_stall_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

  // Buffer payload carries no reset; validity is tracked by valid_q.
  always_ff @(posedge clk) begin
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

  assign bus.wb_stall  = wb_stall_q;
  assign bus.lr_ready  = (occ_q < OCC_W'(DEPTH));
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_data   = rf_data_q;
  assign bus.q_pending = hit;
  assign bus.occupancy = occ_q;
endmodule
